// File: rtl/multi_buffer_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module : buffer_ctrl_pkg
// Brief  : Shared types and wrap helper for multi_buffer_controller
//          (optional statistics enabled by BUFFER_CTRL_STATS_EN).
// Rev    : 1.0
// ============================================================================
package buffer_ctrl_pkg;

   typedef enum logic [2:0] {
      BUF_AVAILABLE  = 3'd0,
      BUF_WRITE_BUSY = 3'd1,
      BUF_UPDATED    = 3'd2,
      BUF_READ_BUSY  = 3'd3,
      BUF_DISPLAYED  = 3'd4
   } buf_state_t;

   typedef enum logic [1:0] {
      W_IDLE   = 2'd0,
      W_SEARCH = 2'd1,
      W_BUSY   = 2'd2
   } wr_state_t;

   typedef enum logic [1:0] {
      R_IDLE   = 2'd0,
      R_SEARCH = 2'd1,
      R_BUSY   = 2'd2
   } rd_state_t;

   function automatic int next_idx(input int idx, input int n);
      return (idx >= n - 1) ? 0 : idx + 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/multi_buffer_controller_if.sv
`default_nettype none
// ============================================================================
// Module : multi_buffer_controller_if
// Brief  : Writer/reader request-grant-done channels of the buffer arbiter.
// Rev    : 1.0
// ============================================================================
interface multi_buffer_controller_if #(
   parameter int ID_W      = 2,
   parameter int SEQ_WIDTH = 8
);
   logic                 wr_req;
   logic                 wr_done;
   logic                 wr_grant;
   logic [ID_W-1:0]      wr_buf_id;
   logic                 rd_req;
   logic                 rd_done;
   logic                 rd_grant;
   logic [ID_W-1:0]      rd_buf_id;
   logic [SEQ_WIDTH-1:0] rd_seq;
   logic                 rd_repeat;

   modport master (
      output wr_req, wr_done, rd_req, rd_done,
      input  wr_grant, wr_buf_id, rd_grant, rd_buf_id, rd_seq, rd_repeat
   );

   modport slave (
      input  wr_req, wr_done, rd_req, rd_done,
      output wr_grant, wr_buf_id, rd_grant, rd_buf_id, rd_seq, rd_repeat
   );
endinterface
`default_nettype wire

// File: rtl/rr_buffer_picker.sv
`default_nettype none
// ============================================================================
// Module : rr_buffer_picker
// Brief  : Combinational round-robin first-eligible search from a start index.
// Rev    : 1.0
// ============================================================================
module rr_buffer_picker
   import buffer_ctrl_pkg::*;
#(
   parameter int NUM_BUFFERS = 3,
   parameter int ID_W        = $clog2(NUM_BUFFERS)
) (
   input  wire logic [NUM_BUFFERS-1:0] i_elig,
   input  wire logic [ID_W-1:0]        i_start,
   output logic      [ID_W-1:0]        o_idx,
   output logic                        o_found
);
   logic [ID_W-1:0] w_cand;

   always_comb begin
      o_idx   = '0;
      o_found = 1'b0;
      w_cand  = i_start;
      for (int k = 0; k < NUM_BUFFERS; k++) begin
         if (!o_found && i_elig[w_cand]) begin
            o_found = 1'b1;
            o_idx   = w_cand;
         end
         w_cand = ID_W'(next_idx(int'(w_cand), NUM_BUFFERS));
      end
   end
endmodule
`default_nettype wire

// File: rtl/multi_buffer_controller.sv
`default_nettype none
// ============================================================================
// Module : multi_buffer_controller
// Brief  : N-buffer frame arbiter between one writer and one reader; optional
//          drop/repeat counters enabled by BUFFER_CTRL_STATS_EN.
// Rev    : 1.0
// ============================================================================
module multi_buffer_controller
   import buffer_ctrl_pkg::*;
#(
   parameter int NUM_BUFFERS = 3,
   parameter int SEQ_WIDTH   = 8
) (
   input wire logic                  clk,
   input wire logic                  reset,
   multi_buffer_controller_if.slave  bus
`ifdef BUFFER_CTRL_STATS_EN
   ,
   output logic [15:0]               frames_dropped,
   output logic [15:0]               frames_repeated
`endif
);
   localparam int ID_W = $clog2(NUM_BUFFERS);

   if (NUM_BUFFERS < 3) begin : g_param_check
      $error("multi_buffer_controller: NUM_BUFFERS must be at least 3");
   end

   buf_state_t           r_buf_st  [NUM_BUFFERS];
   logic [SEQ_WIDTH-1:0] r_buf_tag [NUM_BUFFERS];
   logic [ID_W-1:0]      r_newest;
   logic                 r_has_frame;
   logic [ID_W-1:0]      r_wr_last;
   logic [SEQ_WIDTH-1:0] r_seq_cnt;
   wr_state_t            r_wr_st;
   rd_state_t            r_rd_st;
   logic [ID_W-1:0]      r_wr_id;
   logic [ID_W-1:0]      r_rd_id;
   logic                 r_wr_grant;
   logic                 r_rd_grant;
   logic [SEQ_WIDTH-1:0] r_rd_seq;
   logic                 r_rd_repeat;

   logic [NUM_BUFFERS-1:0] w_elig;
   logic [ID_W-1:0]        w_start;
   logic [ID_W-1:0]        w_pick;
   logic                   w_found;
   logic                   w_wr_take;
   logic                   w_rd_take;

   // The writer must never land on the buffer being read or the newest frame.
   for (genvar gi = 0; gi < NUM_BUFFERS; gi++) begin : g_elig
      assign w_elig[gi] = (r_buf_st[gi] != BUF_READ_BUSY) &&
                          !(r_has_frame && (r_newest == ID_W'(gi)));
   end

   assign w_start = ID_W'(next_idx(int'(r_wr_last), NUM_BUFFERS));

   rr_buffer_picker #(
      .NUM_BUFFERS (NUM_BUFFERS),
      .ID_W        (ID_W)
   ) u_picker (
      .i_elig  (w_elig),
      .i_start (w_start),
      .o_idx   (w_pick),
      .o_found (w_found)
   );

   assign w_wr_take = (r_wr_st == W_SEARCH) && bus.wr_req && w_found;
   assign w_rd_take = (r_rd_st == R_SEARCH) && bus.rd_req && r_has_frame;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_BUFFERS; i++) begin
            r_buf_st[i]  <= BUF_AVAILABLE;
            r_buf_tag[i] <= '0;
         end
         r_newest    <= '0;
         r_has_frame <= 1'b0;
         r_wr_last   <= ID_W'(NUM_BUFFERS - 1);
         r_seq_cnt   <= '0;
         r_wr_st     <= W_IDLE;
         r_rd_st     <= R_IDLE;
         r_wr_id     <= '0;
         r_rd_id     <= '0;
         r_wr_grant  <= 1'b0;
         r_rd_grant  <= 1'b0;
         r_rd_seq    <= '0;
         r_rd_repeat <= 1'b0;
      end else begin
         r_wr_grant <= 1'b0;
         r_rd_grant <= 1'b0;

         case (r_wr_st)
            W_IDLE:   if (bus.wr_req) r_wr_st <= W_SEARCH;
            W_SEARCH: begin
               if (!bus.wr_req) begin
                  r_wr_st <= W_IDLE;
               end else if (w_wr_take) begin
                  r_buf_st[w_pick] <= BUF_WRITE_BUSY;
                  r_wr_id          <= w_pick;
                  r_wr_last        <= w_pick;
                  r_wr_grant       <= 1'b1;
                  r_wr_st          <= W_BUSY;
               end
            end
            W_BUSY: begin
               if (bus.wr_done) begin
                  r_buf_st[r_wr_id]  <= BUF_UPDATED;
                  r_buf_tag[r_wr_id] <= r_seq_cnt;
                  r_newest           <= r_wr_id;
                  r_has_frame        <= 1'b1;
                  r_seq_cnt          <= r_seq_cnt + SEQ_WIDTH'(1);
                  r_wr_st            <= W_IDLE;
               end
            end
            default:  r_wr_st <= W_IDLE;
         endcase

         // Reader sees only registered newest_ptr, so a same-edge wr_done
         // becomes visible one cycle later.
         case (r_rd_st)
            R_IDLE:   if (bus.rd_req) r_rd_st <= R_SEARCH;
            R_SEARCH: begin
               if (!bus.rd_req) begin
                  r_rd_st <= R_IDLE;
               end else if (w_rd_take) begin
                  r_buf_st[r_newest] <= BUF_READ_BUSY;
                  r_rd_id            <= r_newest;
                  r_rd_seq           <= r_buf_tag[r_newest];
                  r_rd_repeat        <= (r_buf_st[r_newest] == BUF_DISPLAYED);
                  r_rd_grant         <= 1'b1;
                  r_rd_st            <= R_BUSY;
               end
            end
            R_BUSY: begin
               if (bus.rd_done) begin
                  r_buf_st[r_rd_id] <= BUF_DISPLAYED;
                  r_rd_st           <= R_IDLE;
               end
            end
            default:  r_rd_st <= R_IDLE;
         endcase
      end
   end

   assign bus.wr_grant  = r_wr_grant;
   assign bus.wr_buf_id = r_wr_id;
   assign bus.rd_grant  = r_rd_grant;
   assign bus.rd_buf_id = r_rd_id;
   assign bus.rd_seq    = r_rd_seq;
   assign bus.rd_repeat = r_rd_repeat;

`ifdef BUFFER_CTRL_STATS_EN
   logic [15:0] r_dropped;
   logic [15:0] r_repeated;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_dropped  <= '0;
         r_repeated <= '0;
      end else begin
         if (w_wr_take && (r_buf_st[w_pick] == BUF_UPDATED) && (r_dropped != 16'hFFFF))
            r_dropped <= r_dropped + 16'd1;
         if (w_rd_take && (r_buf_st[r_newest] == BUF_DISPLAYED) && (r_repeated != 16'hFFFF))
            r_repeated <= r_repeated + 16'd1;
      end
   end

   assign frames_dropped  = r_dropped;
   assign frames_repeated = r_repeated;
`endif
endmodule
`default_nettype wire
